// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg
//   Generic pipeline stage register with a valid/ready handshake and an
//   optional second (skid) entry. It carries a control field, a flat payload
//   and the instruction word. Empty slots are shown as NOP bubbles. The stage
//   also counts the cycles in which the output is stalled.
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   flush                    synchronous kill of all held entries
//   in_valid/in_ready        upstream handshake
//   in_ctrl/in_payload/in_inst    upstream entry
//   out_valid/out_ready      downstream handshake
//   out_ctrl/out_payload/out_inst head entry (ctrl/inst bubble-masked)
//   occupancy                entries held (0..2)
//   stall_cnt                saturating count of out_valid & !out_ready cycles
module pipe_stage_skid_reg #(
  parameter int                CTRL_W    = 3,
  parameter int                PAYLOAD_W = 256,
  parameter int                INST_W    = 32,
  parameter logic [INST_W-1:0] NOP_INST  = 32'h00000013,
  parameter int                SKID      = 1,
  parameter int                CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CTRL_W-1:0]    in_ctrl,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [INST_W-1:0]    in_inst,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CTRL_W-1:0]    out_ctrl,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [INST_W-1:0]    out_inst,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FULL1 = 2'd1,
    S_FULL2 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                 state, state_n;
  logic                   acc, drn;
  logic                   main_ld, main_from_skid, skid_ld;

  logic [CTRL_W-1:0]      main_ctrl, skid_ctrl;
  logic [PAYLOAD_W-1:0]   main_payload, skid_payload;
  logic [INST_W-1:0]      main_inst, skid_inst;

  // Output valid comes from registered state only.
  assign out_valid = (state != S_EMPTY);
  assign occupancy = 2'(state);

  // With the skid entry, in_ready depends only on registered state. This
  // breaks the out_ready -> in_ready timing path. Without it, the stage can
  // take a new entry whenever the head entry leaves in the same cycle.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = (state != S_FULL2);
    end else begin : g_noskid
      assign in_ready = (state == S_EMPTY) | out_ready;
    end
  endgenerate

  assign acc = in_valid & in_ready;
  assign drn = out_valid & out_ready;

  assign out_ctrl    = out_valid ? main_ctrl : '0;
  assign out_inst    = out_valid ? main_inst : NOP_INST;
  assign out_payload = main_payload;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        state <= S_EMPTY;
    else if (flush) state <= S_EMPTY;
    else            state <= state_n;
  end

  always_comb begin
    state_n        = state;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    unique case (state)
      S_EMPTY: begin
        if (acc) begin
          state_n = S_FULL1;
          main_ld = 1'b1;
        end
      end
      S_FULL1: begin
        if (acc && drn) begin
          main_ld = 1'b1;
        end else if (acc && (SKID != 0)) begin
          // Without the skid entry, acc implies drn here.
          state_n = S_FULL2;
          skid_ld = 1'b1;
        end else if (drn) begin
          state_n = S_EMPTY;
        end
      end
      S_FULL2: begin
        if (drn) begin
          state_n        = S_FULL1;
          main_from_skid = 1'b1;
        end
      end
      default: state_n = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_ctrl    <= '0;
      main_payload <= '0;
      main_inst    <= NOP_INST;
      skid_ctrl    <= '0;
      skid_payload <= '0;
      skid_inst    <= NOP_INST;
    end else if (flush) begin
      main_ctrl    <= '0;
      main_payload <= '0;
      main_inst    <= NOP_INST;
      skid_ctrl    <= '0;
      skid_payload <= '0;
      skid_inst    <= NOP_INST;
    end else begin
      if (main_ld) begin
        main_ctrl    <= in_ctrl;
        main_payload <= in_payload;
        main_inst    <= in_inst;
      end else if (main_from_skid) begin
        main_ctrl    <= skid_ctrl;
        main_payload <= skid_payload;
        main_inst    <= skid_inst;
      end
      if (skid_ld) begin
        skid_ctrl    <= in_ctrl;
        skid_payload <= in_payload;
        skid_inst    <= in_inst;
      end
    end
  end

  // The counter survives a flush. During the flush cycle it does not count,
  // so the flush leaves it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (!flush && out_valid && !out_ready && (stall_cnt != CNT_MAX))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg.
// Instance a is the default build, b has no skid entry, and c has a 4-bit
// stall counter.
module tb_pipe_stage_skid_reg;

  localparam logic [31:0] NOP = 32'h00000013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // DUT a: SKID=1, CNT_W=16
  logic a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [2:0] a_in_ctrl, a_out_ctrl;
  logic [255:0] a_in_payload, a_out_payload;
  logic [31:0] a_in_inst, a_out_inst;
  logic [1:0] a_occ;
  logic [15:0] a_stall;

  // DUT b: SKID=0
  logic b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [2:0] b_in_ctrl, b_out_ctrl;
  logic [255:0] b_in_payload, b_out_payload;
  logic [31:0] b_in_inst, b_out_inst;
  logic [1:0] b_occ;
  logic [15:0] b_stall;

  // DUT c: CNT_W=4
  logic c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [2:0] c_in_ctrl, c_out_ctrl;
  logic [255:0] c_in_payload, c_out_payload;
  logic [31:0] c_in_inst, c_out_inst;
  logic [1:0] c_occ;
  logic [3:0] c_stall;

  pipe_stage_skid_reg u_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl),
    .in_payload(a_in_payload), .in_inst(a_in_inst),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl),
    .out_payload(a_out_payload), .out_inst(a_out_inst),
    .occupancy(a_occ), .stall_cnt(a_stall)
  );

  pipe_stage_skid_reg #(.SKID(0)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl),
    .in_payload(b_in_payload), .in_inst(b_in_inst),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl),
    .out_payload(b_out_payload), .out_inst(b_out_inst),
    .occupancy(b_occ), .stall_cnt(b_stall)
  );

  pipe_stage_skid_reg #(.CNT_W(4)) u_c (
    .clk(clk), .rst(rst), .flush(c_flush),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_ctrl(c_in_ctrl),
    .in_payload(c_in_payload), .in_inst(c_in_inst),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_ctrl(c_out_ctrl),
    .out_payload(c_out_payload), .out_inst(c_out_inst),
    .occupancy(c_occ), .stall_cnt(c_stall)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_ctrl = 0; a_in_payload = 0; a_in_inst = 0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_ctrl = 0; b_in_payload = 0; b_in_inst = 0;
    c_flush = 0; c_in_valid = 0; c_out_ready = 0; c_in_ctrl = 0; c_in_payload = 0; c_in_inst = 0;

    tick(); tick();
    rst = 1'b0;
    tick();

    // reset then idle
    chk("rst_out_valid", 256'(a_out_valid), 256'd0);
    chk("rst_out_inst", 256'(a_out_inst), 256'(NOP));
    chk("rst_out_ctrl", 256'(a_out_ctrl), 256'd0);
    chk("rst_out_payload", a_out_payload, 256'd0);
    chk("rst_occ", 256'(a_occ), 256'd0);
    chk("rst_in_ready", 256'(a_in_ready), 256'd1);
    chk("rst_stall", 256'(a_stall), 256'd0);

    // streaming: 1,2,3 in, 1,2,3 out one cycle later
    a_out_ready = 1; a_in_valid = 1; a_in_ctrl = 3'b101;
    a_in_payload = 256'd1; a_in_inst = 32'h00100093;
    tick();
    chk("str1_valid", 256'(a_out_valid), 256'd1);
    chk("str1_payload", a_out_payload, 256'd1);
    chk("str1_inst", 256'(a_out_inst), 256'h00100093);
    chk("str1_ctrl", 256'(a_out_ctrl), 256'd5);
    chk("str1_occ", 256'(a_occ), 256'd1);
    a_in_payload = 256'd2; a_in_inst = 32'h00200093;
    tick();
    chk("str2_payload", a_out_payload, 256'd2);
    chk("str2_inst", 256'(a_out_inst), 256'h00200093);
    chk("str2_occ", 256'(a_occ), 256'd1);
    a_in_payload = 256'd3; a_in_inst = 32'h00300093;
    tick();
    chk("str3_payload", a_out_payload, 256'd3);
    chk("str3_occ", 256'(a_occ), 256'd1);
    a_in_valid = 0;
    tick();
    chk("str_end_valid", 256'(a_out_valid), 256'd0);
    chk("str_end_inst", 256'(a_out_inst), 256'(NOP));
    chk("str_end_ctrl", 256'(a_out_ctrl), 256'd0);
    chk("str_end_payload_hold", a_out_payload, 256'd3);
    chk("str_end_stall", 256'(a_stall), 256'd0);

    // back-pressure: A,B pushed while stalled
    a_out_ready = 0; a_in_valid = 1; a_in_ctrl = 3'b001;
    a_in_payload = 256'hA; a_in_inst = 32'h00A00093;
    tick();
    chk("bp_a_payload", a_out_payload, 256'hA);
    chk("bp_a_stall", 256'(a_stall), 256'd0);
    a_in_payload = 256'hB; a_in_inst = 32'h00B00093; a_in_ctrl = 3'b010;
    tick();
    chk("bp_occ2", 256'(a_occ), 256'd2);
    chk("bp_in_ready0", 256'(a_in_ready), 256'd0);
    chk("bp_hold_a", a_out_payload, 256'hA);
    chk("bp_hold_ctrl", 256'(a_out_ctrl), 256'd1);
    chk("bp_stall1", 256'(a_stall), 256'd1);
    a_in_valid = 0;
    tick();
    chk("bp_stall2", 256'(a_stall), 256'd2);
    chk("bp_hold_a2", a_out_payload, 256'hA);
    chk("bp_hold_inst", 256'(a_out_inst), 256'h00A00093);
    a_out_ready = 1;
    tick();
    chk("bp_deliver_b", a_out_payload, 256'hB);
    chk("bp_b_ctrl", 256'(a_out_ctrl), 256'd2);
    chk("bp_in_ready1", 256'(a_in_ready), 256'd1);
    chk("bp_occ1", 256'(a_occ), 256'd1);
    chk("bp_stall_keep", 256'(a_stall), 256'd2);
    tick();
    chk("bp_empty", 256'(a_out_valid), 256'd0);

    // flush with two held entries while C is offered
    a_out_ready = 0; a_in_valid = 1; a_in_payload = 256'h1A; a_in_ctrl = 3'b011;
    tick();
    a_in_payload = 256'h1B;
    tick();
    chk("fl_pre_occ", 256'(a_occ), 256'd2);
    chk("fl_pre_stall", 256'(a_stall), 256'd3);
    a_flush = 1; a_in_payload = 256'hC; a_in_inst = 32'h00C00093;
    tick();
    chk("fl_valid", 256'(a_out_valid), 256'd0);
    chk("fl_ctrl", 256'(a_out_ctrl), 256'd0);
    chk("fl_inst", 256'(a_out_inst), 256'(NOP));
    chk("fl_occ", 256'(a_occ), 256'd0);
    chk("fl_payload", a_out_payload, 256'd0);
    chk("fl_stall", 256'(a_stall), 256'd3);
    a_flush = 0; a_in_valid = 0; a_out_ready = 1;
    tick();
    chk("fl_no_c", 256'(a_out_valid), 256'd0);

    // no-skid build: in_ready follows out_ready combinationally
    b_in_valid = 1; b_in_payload = 256'h55; b_out_ready = 0;
    tick();
    chk("ns_occ1", 256'(b_occ), 256'd1);
    chk("ns_in_ready0", 256'(b_in_ready), 256'd0);
    chk("ns_payload", b_out_payload, 256'h55);
    b_in_valid = 0; b_out_ready = 1;
    #1;
    chk("ns_in_ready_comb", 256'(b_in_ready), 256'd1);
    tick();
    chk("ns_drained", 256'(b_occ), 256'd0);

    // saturating stall counter
    c_in_valid = 1; c_in_payload = 256'h77; c_in_ctrl = 3'b111; c_out_ready = 0;
    tick();
    c_in_valid = 0;
    for (int i = 0; i < 15; i++) tick();
    chk("sat_15", 256'(c_stall), 256'd15);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_hold", 256'(c_stall), 256'd15);
    chk("sat_valid", 256'(c_out_valid), 256'd1);
    chk("sat_ctrl", 256'(c_out_ctrl), 256'd7);

    // asynchronous reset mid-cycle
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", 256'(c_out_valid), 256'd0);
    chk("arst_stall", 256'(c_stall), 256'd0);
    chk("arst_occ", 256'(c_occ), 256'd0);
    chk("arst_inst", 256'(c_out_inst), 256'(NOP));
    chk("arst_ctrl", 256'(c_out_ctrl), 256'd0);
    chk("arst_payload", c_out_payload, 256'd0);
    chk("arst_in_ready", 256'(c_in_ready), 256'd1);
    #2;
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
